// File: rtl/pc_update_seq.sv
// Registered program-counter unit for the sequential Y86-64 core, with a
// return-address stack that cross-checks every ret and a halt/error state machine.
module pc_update_seq #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
    parameter int                RAS_DEPTH = 8,
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire,
    input  logic              stall,
    input  logic [3:0]        icode,
    input  logic              Cnd,
    input  logic [ADDR_W-1:0] valP,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valM,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] next_pc,
    output logic [1:0]        state,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ret_mispredict,
    output logic              ras_underflow,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(RAS_DEPTH);

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;
    localparam logic [3:0] IC_MAX  = 4'hB;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nx_s;
    logic [ADDR_W-1:0]   next_pc_s;
    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W-1:0]    ptr_nx_s;
    logic [PTR_W-1:0]    ptr_dec_s;
    logic [OCC_W-1:0]    occ_r;
    logic [OCC_W-1:0]    occ_nx_s;
    logic                mispredict_r;
    logic                mispredict_nx_s;
    logic                underflow_r;
    logic                underflow_nx_s;
    logic [CNT_W-1:0]    ovf_cnt_r;
    logic [CNT_W-1:0]    ovf_cnt_nx_s;
    logic [CNT_W-1:0]    mis_cnt_r;
    logic [CNT_W-1:0]    mis_cnt_nx_s;
    logic                ras_we_s;
    logic [ADDR_W-1:0]   ras_top_s;
    logic                ras_empty_s;
    logic                ras_full_s;
    logic                commit_s;
    logic [ADDR_W-1:0]   ras_mem_r [RAS_DEPTH];

    // ptr_r is the next free slot, so the top entry sits one below it (mod depth)
    assign ptr_dec_s   = ptr_r - PTR_ONE;
    assign ras_top_s   = ras_mem_r[ptr_dec_s];
    assign ras_empty_s = (occ_r == OCC_ZERO);
    assign ras_full_s  = (occ_r == OCC_MAX);
    assign commit_s    = retire & ~stall & (state_r == ST_RUN);

    // Next-PC selection from the retiring instruction's class
    always_comb begin
        next_pc_s = valP;
        case (icode)
            IC_JXX: begin
                if (Cnd) begin
                    next_pc_s = valC;
                end else begin
                    next_pc_s = valP;
                end
            end
            IC_CALL: next_pc_s = valC;
            IC_RET:  next_pc_s = valM;
            default: next_pc_s = valP;
        endcase
    end

    // Run/halt/error next-state logic; HALT and ERR only leave through rst
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (commit_s && (icode == IC_HALT)) begin
                    state_nx_s = ST_HALT;
                end else if (commit_s && (icode > IC_MAX)) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALT: state_nx_s = ST_HALT;
            ST_ERR:  state_nx_s = ST_ERR;
            default: state_nx_s = ST_ERR;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // PC, RAS bookkeeping and event counters for a committing instruction
    always_comb begin
        pc_nx_s         = pc_r;
        ptr_nx_s        = ptr_r;
        occ_nx_s        = occ_r;
        mispredict_nx_s = 1'b0;
        underflow_nx_s  = 1'b0;
        ovf_cnt_nx_s    = ovf_cnt_r;
        mis_cnt_nx_s    = mis_cnt_r;
        ras_we_s        = 1'b0;
        if (commit_s && (icode != IC_HALT) && (icode <= IC_MAX)) begin
            pc_nx_s = next_pc_s;
            case (icode)
                IC_CALL: begin
                    ras_we_s = 1'b1;
                    ptr_nx_s = ptr_r + PTR_ONE;
                    if (ras_full_s) begin
                        ovf_cnt_nx_s = sat_inc(ovf_cnt_r);
                    end else begin
                        occ_nx_s = occ_r + OCC_ONE;
                    end
                end
                IC_RET: begin
                    if (ras_empty_s) begin
                        underflow_nx_s = 1'b1;
                    end else begin
                        ptr_nx_s = ptr_dec_s;
                        occ_nx_s = occ_r - OCC_ONE;
                        if (ras_top_s != valM) begin
                            mispredict_nx_s = 1'b1;
                            mis_cnt_nx_s    = sat_inc(mis_cnt_r);
                        end else begin
                            mispredict_nx_s = 1'b0;
                        end
                    end
                end
                default: begin
                    ras_we_s = 1'b0;
                end
            endcase
        end else begin
            pc_nx_s = pc_r;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            ptr_r        <= {PTR_W{1'b0}};
            occ_r        <= OCC_ZERO;
            mispredict_r <= 1'b0;
            underflow_r  <= 1'b0;
            ovf_cnt_r    <= {CNT_W{1'b0}};
            mis_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            pc_r         <= pc_nx_s;
            ptr_r        <= ptr_nx_s;
            occ_r        <= occ_nx_s;
            mispredict_r <= mispredict_nx_s;
            underflow_r  <= underflow_nx_s;
            ovf_cnt_r    <= ovf_cnt_nx_s;
            mis_cnt_r    <= mis_cnt_nx_s;
        end
    end

    // RAS storage; a push when full lands on the oldest slot, overwriting it
    always_ff @(posedge clk) begin
        if (ras_we_s) begin
            ras_mem_r[ptr_r] <= valP;
        end
    end

    assign PC             = pc_r;
    assign next_pc        = next_pc_s;
    assign state          = state_r;
    assign ras_empty      = ras_empty_s;
    assign ras_full       = ras_full_s;
    assign ret_mispredict = mispredict_r;
    assign ras_underflow  = underflow_r;
    assign overflow_cnt   = ovf_cnt_r;
    assign mispredict_cnt = mis_cnt_r;

endmodule

// File: doc/pc_update_seq.md
Name: pc_update_seq

Overview:
- Registered program-counter unit for the sequential Y86-64 core.
- Selects the next PC from valP, valC or valM according to icode and Cnd. Commits it on a retire strobe and holds the PC through stalls.
- Adds a parametrised return-address stack (RAS) that checks every ret's valM against the predicted return address.
- Adds a halt/error state machine that freezes the PC on halt or invalid icode.

Parameters:
ADDR_W, 64, width of PC and of valP/valC/valM.
RESET_PC, 0, PC value loaded on reset.
RAS_DEPTH, 8, return-address stack entries (power of two, >=2).
CNT_W, 8, width of saturating event counters.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
retire  in  1  current instruction completes this cycle; commit next PC.
stall  in  1  hold PC and RAS regardless of retire.
icode  in  4  instruction code of the retiring instruction.
Cnd  in  1  branch condition from execute.
valP  in  ADDR_W  incremented PC.
valC  in  ADDR_W  instruction constant.
valM  in  ADDR_W  value read from memory.
PC  out  ADDR_W  registered current PC.
next_pc  out  ADDR_W  combinational selected next PC.
state  out  2  00 RUN, 01 HALT, 10 ERR.
ras_empty  out  1  RAS holds no valid entry.
ras_full  out  1  RAS holds RAS_DEPTH entries.
ret_mispredict  out  1  one-cycle pulse: committed ret had valM != RAS top.
ras_underflow  out  1  one-cycle pulse: ret committed with RAS empty.
overflow_cnt  out  CNT_W  saturating count of calls that overwrote the oldest entry.
mispredict_cnt  out  CNT_W  saturating count of ret_mispredict events.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=RUN, RAS pointer=0, RAS occupancy=0.
  - Both pulses 0, both counters 0.
  - RAS entry contents are don't-care.
- next_pc selection (combinational, every cycle, independent of retire/state):
  - icode 7: Cnd ? valC : valP.
  - icode 8: valC.
  - icode 9: valM.
  - All other icodes: valP.
- Commit condition: commit = retire & ~stall & (state==RUN). Latency: PC takes next_pc on the rising edge at which commit is sampled high.
- Without commit, PC, RAS and counters hold; pulses are 0 the next cycle.
- State machine:
  - RUN, commit with icode 0 -> HALT. PC does not advance; it stays at the halt instruction's address.
  - RUN, commit with icode > 4'hB -> ERR. PC is held.
  - HALT and ERR are absorbing until rst.
  - Other icodes stay in RUN.
- RAS, updated on commit only:
  - Circular buffer with top pointer and occupancy count 0..RAS_DEPTH.
  - call (8): push valP.
    - If not full, occupancy+1.
    - If full, the oldest entry is overwritten, occupancy stays RAS_DEPTH, and overflow_cnt+1 (saturating).
  - ret (9), non-empty: pop; compare the popped entry with valM.
    - On mismatch, ret_mispredict=1 for the cycle after the commit edge and mispredict_cnt+1 (saturating).
    - PC still takes valM (the memory value is architectural).
  - ret (9), empty: no pop; ras_underflow=1 for the cycle after the commit edge; no mispredict.
  - Other icodes leave the RAS unchanged.
- Flags: ras_empty = (occupancy==0); ras_full = (occupancy==RAS_DEPTH).
- Counters: stop at all-ones; no wrap.
- Arithmetic: no arithmetic on PC values. valP is computed upstream; all paths are ADDR_W wide with no truncation.
- Simultaneous events:
  - stall dominates retire.
  - rst dominates everything, including mid-commit; the RAS is cleared.
  - A ret right after a call in consecutive commits pops the just-pushed value.

Test Plan:
- Reset/hold: rst with RESET_PC=0x100, then retire=0 for 5 cycles -> PC=0x100, state=RUN, ras_empty=1, counters 0.
- Jump: commit icode=7, valC=0x400, valP=0x109: with Cnd=1 -> PC=0x400; with Cnd=0 -> PC=0x109. With stall=1 and retire=1 -> PC unchanged.
- Call/ret match: commit call valC=0x800, valP=0x20A -> PC=0x800, ras_empty=0. Then commit ret valM=0x20A -> PC=0x20A, no mispredict, ras_empty=1.
- Mismatch/underflow: push 0x20A, then ret valM=0x300 -> PC=0x300, ret_mispredict pulses once, mispredict_cnt=1. A further ret -> ras_underflow pulse, PC=valM.
- Overflow: RAS_DEPTH=8, 9 calls with valP=1..9 -> overflow_cnt=1, ras_full=1. 8 rets popping in order 9..2 -> no mispredicts when valM matches; then ras_empty=1.
- Halt/error: commit icode=0 at PC=0x50 -> state=HALT, PC=0x50, later commits ignored. After rst, commit icode=0xE -> state=ERR, PC held. Assert rst mid-stall -> state=RUN, PC=RESET_PC.
